// File: rtl/dvi_framebuffer_pixel_out_pkg.sv
// Shared definitions for the DVI framebuffer pixel output path:
// raster timing presets, RGB565 field layout, RGB888 pixel type,
// colour-bar table and the RGB565 -> RGB888 expansion helper.
package dvi_framebuffer_pixel_out_pkg;

  // 640x480@60 (25.175 MHz pixel clock), active-low syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_SYNC_POL = 1'b0;

  // 800x600@60 (40 MHz pixel clock), active-high syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_SYNC_POL = 1'b1;

  // RGB565 field positions inside one 16-bit pixel
  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_MSB = 4;
  localparam int RGB565_B_LSB = 0;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  // Colour bars, index 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][23:0] COLOUR_BARS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // Replicate the top bits into the low bits so full-scale stays full-scale
  function automatic rgb888_t rgb565_to_888(input logic [15:0] px);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    rgb888_t    c;
    r5 = px[RGB565_R_MSB:RGB565_R_LSB];
    g6 = px[RGB565_G_MSB:RGB565_G_LSB];
    b5 = px[RGB565_B_MSB:RGB565_B_LSB];
    c.red   = {r5, r5[4:2]};
    c.green = {g6, g6[5:4]};
    c.blue  = {b5, b5[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/dvi_framebuffer_pixel_out_timing_gen.sv
// Raster timing generator: horizontal/vertical counters and the
// combinational region flags derived from them (active, syncs, start of
// frame, pixel half-select). The consumer registers these flags.
// With DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN defined it also
// reports which colour bar the current pixel falls in.
module dvi_framebuffer_pixel_out_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic sof,
  output logic half
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
  ,
  output logic [2:0] bar
`endif
);

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [11:0] h_q;
  logic [11:0] v_q;

  // Raster counters; held at 0,0 while disabled so a re-enable restarts the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!enable) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      v_q <= (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end else begin
      h_q <= h_q + 12'd1;
    end
  end

  // Region decode; everything reads as blank/inactive while disabled
  always_comb begin
    active = enable && (h_q < H_ACT) && (v_q < V_ACT);
    hsync  = (enable && (h_q >= HS_START) && (h_q < HS_END)) ? SYNC_POL : !SYNC_POL;
    vsync  = (enable && (v_q >= VS_START) && (v_q < VS_END)) ? SYNC_POL : !SYNC_POL;
    sof    = enable && (h_q == 12'd0) && (v_q == 12'd0);
    half   = h_q[0];
  end

`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  // Bar index by threshold compare, avoiding a divider
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_q >= 12'(i * BAR_W)) bar = 3'(i);
    end
  end
`endif

endmodule

// File: rtl/dvi_framebuffer_pixel_out.sv
// Pixel output stage fed by the framebuffer line FIFO. Pops one 32-bit
// word per two active pixels, unpacks RGB565 to RGB888 and registers
// RGB/hsync/vsync/de for the TMDS encoder, plus sof/underflow pulses.
// Optional colour-bar generator: DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN.
module dvi_framebuffer_pixel_out
  import dvi_framebuffer_pixel_out_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit SYNC_POL = VGA640_SYNC_POL
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
  input  logic        pattern_i,
`endif
  output logic        pop_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        sof_o,
  output logic        underflow_o
);

  logic    active;
  logic    hsync;
  logic    vsync;
  logic    sof;
  logic    half;
  logic [15:0] px_raw;
  rgb888_t px_rgb;
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
  logic [2:0] bar;
`endif

  dvi_framebuffer_pixel_out_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk    (clk_i),
    .rst    (rst_i),
    .enable (enable_i),
    .active (active),
    .hsync  (hsync),
    .vsync  (vsync),
    .sof    (sof),
    .half   (half)
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
    ,
    .bar    (bar)
`endif
  );

  // Pick the pixel half of the FIFO word and expand it to RGB888
  always_comb begin
    px_raw = half ? data_i[31:16] : data_i[15:0];
    px_rgb = rgb565_to_888(px_raw);
  end

  // Word is consumed after its second pixel; a missing word on an odd pixel is skipped
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
  assign pop_o = active & half & valid_i & ~pattern_i;
`else
  assign pop_o = active & half & valid_i;
`endif

  // Output register stage, one cycle behind the counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      red_o       <= '0;
      green_o     <= '0;
      blue_o      <= '0;
      hsync_o     <= !SYNC_POL;
      vsync_o     <= !SYNC_POL;
      de_o        <= 1'b0;
      sof_o       <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      hsync_o <= hsync;
      vsync_o <= vsync;
      sof_o   <= sof;
      de_o    <= active;
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
      if (active && pattern_i) begin
        {red_o, green_o, blue_o} <= COLOUR_BARS[bar];
        underflow_o              <= 1'b0;
      end else
`endif
      if (active && valid_i) begin
        red_o       <= px_rgb.red;
        green_o     <= px_rgb.green;
        blue_o      <= px_rgb.blue;
        underflow_o <= 1'b0;
      end else begin
        red_o       <= '0;
        green_o     <= '0;
        blue_o      <= '0;
        underflow_o <= active;
      end
    end
  end

endmodule

// File: tb/tb_dvi_framebuffer_pixel_out.sv
// Self-checking bench for dvi_framebuffer_pixel_out using a small raster
// (8+2+2+2 by 4+1+1+1). Expected outputs are pushed to a scoreboard when
// stimulus is driven and popped after the following clock edge.
// Set DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN to also check colour bars.
module tb_dvi_framebuffer_pixel_out;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        pop_o;
  logic [7:0]  red_o;
  logic [7:0]  green_o;
  logic [7:0]  blue_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic        sof_o;
  logic        underflow_o;
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
  logic        pattern_i;
`endif

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic        uf;
  } exp_t;

  exp_t sb[$];
  int   mh;
  int   mv;
  logic pattern_m;
  int   asserts;
  int   failures;

  dvi_framebuffer_pixel_out #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
    .pattern_i   (pattern_i),
`endif
    .pop_o       (pop_o),
    .red_o       (red_o),
    .green_o     (green_o),
    .blue_o      (blue_o),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .de_o        (de_o),
    .sof_o       (sof_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [23:0] exp565(input logic [15:0] p);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Drive one cycle, record observed/expected pop_o, push expected registered outputs
  task automatic drive_cycle(input logic en, input logic vld, input logic [31:0] d,
                             output logic pop_seen, output logic pop_exp);
    exp_t        e;
    logic        act;
    logic        odd;
    logic [15:0] px;
    enable_i = en;
    valid_i  = vld;
    data_i   = d;
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
    pattern_i = pattern_m;
`endif
    #1;
    pop_seen = pop_o;
    act      = en && (mh < HA) && (mv < VA);
    odd      = (mh % 2) == 1;
    pop_exp  = act && odd && vld && !pattern_m;
    px       = odd ? d[31:16] : d[15:0];
    e.de     = act;
    e.sof    = en && (mh == 0) && (mv == 0);
    e.hs     = !(en && (mh >= HA + HF) && (mh < HA + HF + HS));
    e.vs     = !(en && (mv >= VA + VF) && (mv < VA + VF + VS));
    e.uf     = act && !vld && !pattern_m;
    e.rgb    = 24'h000000;
    if (act && pattern_m) e.rgb = bar_colour(mh / (HA / 8));
    else if (act && vld)  e.rgb = exp565(px);
    sb.push_back(e);
    if (!en) begin
      mh = 0;
      mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Free-run until the model raster reaches (th, tv)
  task automatic run_to(input int th, input int tv);
    int   n;
    logic ps, pe;
    exp_t e;
    n = 0;
    while (!(mh == th && mv == tv) && n < 4 * HT * VT) begin
      drive_cycle(1'b1, 1'b1, $urandom, ps, pe);
      e = sb.pop_front();
      n++;
    end
    if (!(mh == th && mv == tv)) begin
      failures++;
      $display("[TB] FAIL run_to_timeout got h=%0d v=%0d want h=%0d v=%0d", mh, mv, th, tv);
    end
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    enable_i = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
    pattern_i = 1'b0;
`endif
    #12;
    asserts++; if ({red_o, green_o, blue_o} !== 24'h0) begin failures++; $display("[TB] FAIL reset_rgb got %h want 000000", {red_o, green_o, blue_o}); end
    asserts++; if (de_o !== 1'b0)        begin failures++; $display("[TB] FAIL reset_de got %b want 0", de_o); end
    asserts++; if (hsync_o !== 1'b1)     begin failures++; $display("[TB] FAIL reset_hsync got %b want 1", hsync_o); end
    asserts++; if (vsync_o !== 1'b1)     begin failures++; $display("[TB] FAIL reset_vsync got %b want 1", vsync_o); end
    asserts++; if (sof_o !== 1'b0)       begin failures++; $display("[TB] FAIL reset_sof got %b want 0", sof_o); end
    asserts++; if (underflow_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_underflow got %b want 0", underflow_o); end
    asserts++; if (pop_o !== 1'b0)       begin failures++; $display("[TB] FAIL reset_pop got %b want 0", pop_o); end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    mh = 0;
    mv = 0;
    sb.delete();
  endtask

  task automatic test_timing();
    logic ps, pe;
    exp_t e;
    int   sof_cnt, de_cnt, hs_cnt, first_sof, last_sof;
    sof_cnt = 0; de_cnt = 0; hs_cnt = 0; first_sof = -1; last_sof = -1;
    for (int c = 0; c < 2 * HT * VT; c++) begin
      drive_cycle(1'b1, 1'b1, $urandom, ps, pe);
      e = sb.pop_front();
      asserts++; if (ps !== pe) begin failures++; $display("[TB] FAIL timing_pop cyc=%0d got %b want %b", c, ps, pe); end
      asserts++; if ({red_o, green_o, blue_o} !== e.rgb) begin failures++; $display("[TB] FAIL timing_rgb cyc=%0d got %h want %h", c, {red_o, green_o, blue_o}, e.rgb); end
      asserts++; if (de_o !== e.de)        begin failures++; $display("[TB] FAIL timing_de cyc=%0d got %b want %b", c, de_o, e.de); end
      asserts++; if (hsync_o !== e.hs)     begin failures++; $display("[TB] FAIL timing_hsync cyc=%0d got %b want %b", c, hsync_o, e.hs); end
      asserts++; if (vsync_o !== e.vs)     begin failures++; $display("[TB] FAIL timing_vsync cyc=%0d got %b want %b", c, vsync_o, e.vs); end
      asserts++; if (sof_o !== e.sof)      begin failures++; $display("[TB] FAIL timing_sof cyc=%0d got %b want %b", c, sof_o, e.sof); end
      asserts++; if (underflow_o !== e.uf) begin failures++; $display("[TB] FAIL timing_underflow cyc=%0d got %b want %b", c, underflow_o, e.uf); end
      if (sof_o === 1'b1) begin
        sof_cnt++;
        if (first_sof < 0) first_sof = c;
        last_sof = c;
      end
      if (de_o === 1'b1) de_cnt++;
      if (hsync_o === 1'b0) hs_cnt++;
    end
    asserts++; if (sof_cnt !== 2)   begin failures++; $display("[TB] FAIL timing_sof_count got %0d want 2", sof_cnt); end
    asserts++; if (first_sof !== 0) begin failures++; $display("[TB] FAIL timing_first_sof got %0d want 0", first_sof); end
    asserts++; if (last_sof - first_sof !== HT * VT) begin failures++; $display("[TB] FAIL timing_sof_period got %0d want %0d", last_sof - first_sof, HT * VT); end
    asserts++; if (de_cnt !== 2 * VA * HA) begin failures++; $display("[TB] FAIL timing_de_count got %0d want %0d", de_cnt, 2 * VA * HA); end
    asserts++; if (hs_cnt !== 2 * VT * HS) begin failures++; $display("[TB] FAIL timing_hsync_count got %0d want %0d", hs_cnt, 2 * VT * HS); end
  endtask

  task automatic test_unpack();
    logic        ps, pe;
    exp_t        e;
    logic [23:0] want_rgb;
    logic        want_pop;
    run_to(0, 0);
    for (int h = 0; h < HT; h++) begin
      drive_cycle(1'b1, 1'b1, 32'hF800_07E0, ps, pe);
      e        = sb.pop_front();
      want_pop = (h < HA) && (h % 2 == 1);
      want_rgb = (h >= HA) ? 24'h000000 : ((h % 2 == 1) ? 24'hFF0000 : 24'h00FF00);
      asserts++; if (ps !== want_pop) begin failures++; $display("[TB] FAIL unpack_pop h=%0d got %b want %b", h, ps, want_pop); end
      asserts++; if ({red_o, green_o, blue_o} !== want_rgb) begin failures++; $display("[TB] FAIL unpack_rgb h=%0d got %h want %h", h, {red_o, green_o, blue_o}, want_rgb); end
      asserts++; if (de_o !== e.de) begin failures++; $display("[TB] FAIL unpack_de h=%0d got %b want %b", h, de_o, e.de); end
    end
  endtask

  task automatic test_underflow();
    logic        ps, pe, vld;
    exp_t        e;
    logic [31:0] words [4];
    logic [23:0] want_rgb [8];
    int          idx, uf_cnt;
    words[0] = 32'h001F_F800;
    words[1] = 32'h07E0_FFFF;
    words[2] = 32'hF800_001F;
    words[3] = 32'h0000_0000;
    want_rgb = '{24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000,
                 24'hFFFFFF, 24'h00FF00, 24'h0000FF, 24'hFF0000};
    idx = 0;
    uf_cnt = 0;
    run_to(0, 0);
    for (int h = 0; h < HT; h++) begin
      vld = !(h == 2 || h == 3);
      drive_cycle(1'b1, vld, words[idx], ps, pe);
      e = sb.pop_front();
      if (pe) idx++;
      asserts++; if (ps !== ((h == 1) || (h == 5) || (h == 7))) begin failures++; $display("[TB] FAIL underflow_pop h=%0d got %b", h, ps); end
      asserts++; if (underflow_o !== (h == 2 || h == 3)) begin failures++; $display("[TB] FAIL underflow_pulse h=%0d got %b", h, underflow_o); end
      if (h < HA) begin
        asserts++; if ({red_o, green_o, blue_o} !== want_rgb[h]) begin failures++; $display("[TB] FAIL underflow_rgb h=%0d got %h want %h", h, {red_o, green_o, blue_o}, want_rgb[h]); end
      end
      if (underflow_o === 1'b1) uf_cnt++;
    end
    asserts++; if (uf_cnt !== 2) begin failures++; $display("[TB] FAIL underflow_count got %0d want 2", uf_cnt); end
  endtask

  task automatic test_reset_mid();
    logic ps, pe;
    exp_t e;
    run_to(5, 2);
    asserts++; if (de_o !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pre_de got %b want 1", de_o); end
    rst_i = 1'b1;
    #1;
    asserts++; if ({red_o, green_o, blue_o} !== 24'h0) begin failures++; $display("[TB] FAIL midreset_rgb got %h want 000000", {red_o, green_o, blue_o}); end
    asserts++; if (de_o !== 1'b0)    begin failures++; $display("[TB] FAIL midreset_de got %b want 0", de_o); end
    asserts++; if (hsync_o !== 1'b1) begin failures++; $display("[TB] FAIL midreset_hsync got %b want 1", hsync_o); end
    asserts++; if (vsync_o !== 1'b1) begin failures++; $display("[TB] FAIL midreset_vsync got %b want 1", vsync_o); end
    sb.delete();
    mh = 0;
    mv = 0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    drive_cycle(1'b1, 1'b1, $urandom, ps, pe);
    e = sb.pop_front();
    asserts++; if (sof_o !== 1'b1) begin failures++; $display("[TB] FAIL midreset_sof got %b want 1", sof_o); end
    asserts++; if (de_o !== e.de)  begin failures++; $display("[TB] FAIL midreset_de_after got %b want %b", de_o, e.de); end
  endtask

  task automatic test_enable();
    logic ps, pe;
    exp_t e;
    run_to(3, 1);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFF, ps, pe);
      e = sb.pop_front();
      asserts++; if (ps !== 1'b0)      begin failures++; $display("[TB] FAIL enable_pop c=%0d got %b want 0", c, ps); end
      asserts++; if (hsync_o !== 1'b1) begin failures++; $display("[TB] FAIL enable_hsync c=%0d got %b want 1", c, hsync_o); end
      asserts++; if (vsync_o !== 1'b1) begin failures++; $display("[TB] FAIL enable_vsync c=%0d got %b want 1", c, vsync_o); end
      asserts++; if (de_o !== 1'b0)    begin failures++; $display("[TB] FAIL enable_de c=%0d got %b want 0", c, de_o); end
    end
    for (int c = 0; c < HT; c++) begin
      drive_cycle(1'b1, 1'b1, $urandom, ps, pe);
      e = sb.pop_front();
      asserts++; if (sof_o !== (c == 0)) begin failures++; $display("[TB] FAIL enable_sof c=%0d got %b", c, sof_o); end
      asserts++; if (de_o !== e.de)      begin failures++; $display("[TB] FAIL enable_restart_de c=%0d got %b want %b", c, de_o, e.de); end
      asserts++; if ({red_o, green_o, blue_o} !== e.rgb) begin failures++; $display("[TB] FAIL enable_rgb c=%0d got %h want %h", c, {red_o, green_o, blue_o}, e.rgb); end
    end
  endtask

`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
  task automatic test_pattern();
    logic ps, pe;
    exp_t e;
    run_to(0, 0);
    pattern_m = 1'b1;
    for (int h = 0; h < HT; h++) begin
      drive_cycle(1'b1, 1'b0, $urandom, ps, pe);
      e = sb.pop_front();
      asserts++; if (ps !== 1'b0)          begin failures++; $display("[TB] FAIL pattern_pop h=%0d got %b want 0", h, ps); end
      asserts++; if (underflow_o !== 1'b0) begin failures++; $display("[TB] FAIL pattern_underflow h=%0d got %b want 0", h, underflow_o); end
      asserts++; if ({red_o, green_o, blue_o} !== e.rgb) begin failures++; $display("[TB] FAIL pattern_rgb h=%0d got %h want %h", h, {red_o, green_o, blue_o}, e.rgb); end
      if (h == 0) begin
        asserts++; if ({red_o, green_o, blue_o} !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL pattern_px0 got %h want FFFFFF", {red_o, green_o, blue_o}); end
      end
      if (h == 7) begin
        asserts++; if (({red_o, green_o, blue_o} !== 24'h000000) || (de_o !== 1'b1)) begin failures++; $display("[TB] FAIL pattern_px7 got %h de=%b want 000000 de=1", {red_o, green_o, blue_o}, de_o); end
      end
    end
    pattern_m = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    asserts   = 0;
    failures  = 0;
    mh        = 0;
    mv        = 0;
    pattern_m = 1'b0;
    test_reset();
    test_timing();
    test_unpack();
    test_underflow();
    test_reset_mid();
    test_enable();
`ifdef DVI_FRAMEBUFFER_PIXEL_OUT_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
